// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding,
// constant helper functions and the parameter legality check.
package adder_pkg;

    // Sequencing states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Digit counter width, never narrower than one bit.
    function automatic int counter_width(input int ndig);
        int w;
        w = clog2(ndig);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal when the operand splits evenly into whole digits.
    function automatic bit config_ok(input int width, input int digit);
        return (digit >= 1) && (width >= 2) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_add.sv
// DIGIT-bit ripple-carry adder built from a chain of full-adder stages.
// Purely combinational; the serial adder reuses it once per digit cycle.
module digit_add
    import adder_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit, the carry rippling from bit 0 upward.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB digit
// first, with ready/valid handshakes on the operand and result sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = counter_width(NDIG);

    // Refuse to elaborate when the operand cannot be cut into whole digits.
    if (!config_ok(WIDTH, DIGIT)) begin : g_bad_config
        $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;
    logic              ovf_reg;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout;
    logic [WIDTH-1:0]  sum_shift;
    logic              accept;
    logic              last_digit;

    assign accept = in_valid && in_ready;

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs, derived from the current state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pick the operand digit addressed by the counter; every digit index is a constant mux leg.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                a_dig = a_reg[i*DIGIT +: DIGIT];
                b_dig = b_reg[i*DIGIT +: DIGIT];
            end
        end
        last_digit = (cnt == CW'(NDIG - 1));
    end

    digit_add #(
        .DIGIT (DIGIT)
    ) u_digit_add (
        .x    (a_dig),
        .y    (b_dig),
        .cin  (carry_reg),
        .s    (dig_sum),
        .cout (dig_cout)
    );

    // New digits enter the result from the top so the LSB digit ends up at bit 0.
    if (NDIG == 1) begin : g_single_digit
        assign sum_shift = dig_sum;
    end else begin : g_multi_digit
        assign sum_shift = {dig_sum, sum_reg[WIDTH-1:DIGIT]};
    end

    // Operand capture at the accept edge; B is stored inverted for subtraction so RUN only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
        end
    end

    // Carry and digit counter: seeded at accept (carry 1 supplies the +1 of A+~B+1), advanced each RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            carry_reg <= sub ? 1'b1 : cin;
            cnt       <= '0;
        end else if (state == RUN) begin
            carry_reg <= dig_cout;
            cnt       <= cnt + CW'(1);
        end
    end

    // Result registers change only in RUN, so the last result stays visible through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (state == RUN) begin
            sum_reg <= sum_shift;
            if (last_digit) begin
                cout_reg <= dig_cout;
                ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (dig_sum[DIGIT-1] != a_reg[WIDTH-1]);
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: three instances (DIGIT 4, 1, 16)
// are exercised with directed and random operations against an arithmetic model.
module tb_digit_serial_adder;

    localparam int W = 16;
    localparam int NDIG_V [3] = '{4, 16, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          in_valid_v  [3];
    logic          out_ready_v [3];
    logic          in_ready_v  [3];
    logic          out_valid_v [3];
    logic [W-1:0]  sum_v       [3];
    logic          cout_v      [3];
    logic          ovf_v       [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid_v[0]), .in_ready (in_ready_v[0]),
        .a (a), .b (b), .cin (cin), .sub (sub),
        .out_valid (out_valid_v[0]), .out_ready (out_ready_v[0]),
        .sum (sum_v[0]), .cout (cout_v[0]), .ovf (ovf_v[0])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid_v[1]), .in_ready (in_ready_v[1]),
        .a (a), .b (b), .cin (cin), .sub (sub),
        .out_valid (out_valid_v[1]), .out_ready (out_ready_v[1]),
        .sum (sum_v[1]), .cout (cout_v[1]), .ovf (ovf_v[1])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid_v[2]), .in_ready (in_ready_v[2]),
        .a (a), .b (b), .cin (cin), .sub (sub),
        .out_valid (out_valid_v[2]), .out_ready (out_ready_v[2]),
        .sum (sum_v[2]), .cout (cout_v[2]), .ovf (ovf_v[2])
    );

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rcin, input logic rsub);
        int ua, ub, sa, sb, ures, sres, c;
        logic [W-1:0] s;
        logic         c_out, v;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        c  = rcin ? 1 : 0;
        if (rsub) begin
            ures  = ua - ub;
            sres  = sa - sb;
            c_out = (ua >= ub);
        end else begin
            ures  = ua + ub + c;
            sres  = sa + sb + c;
            c_out = (ures > 65535);
        end
        s = ures[W-1:0];
        v = (sres > 32767) || (sres < -32768);
        return {v, c_out, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge, let one posedge accept them, then scramble the inputs.
    task automatic applyStimulus(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tcin, input logic tsub);
        a   = ta;
        b   = tb;
        cin = tcin;
        sub = tsub;
        in_valid_v[k] = 1'b1;
        checkOutput("in_ready_idle", 32'(in_ready_v[k]), 32'h1);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    // Full operation: accept, latency, result, optional backpressure, release to IDLE.
    task automatic runOp(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub, input int stall);
        logic [17:0] exp;
        int lat;
        exp = refModel(ta, tb, tcin, tsub);
        out_ready_v[k] = (stall == 0);
        applyStimulus(k, ta, tb, tcin, tsub);
        lat = 0;
        while (out_valid_v[k] !== 1'b1 && lat < 64) begin
            checkOutput("in_ready_busy", 32'(in_ready_v[k]), 32'h0);
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(NDIG_V[k]));
        checkOutput("sum", 32'(sum_v[k]), 32'(exp[15:0]));
        checkOutput("cout", 32'(cout_v[k]), 32'(exp[16]));
        checkOutput("ovf", 32'(ovf_v[k]), 32'(exp[17]));
        for (int s = 0; s < stall; s++) begin
            in_valid_v[k] = ~in_valid_v[k];
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("hold", 32'({out_valid_v[k], in_ready_v[k], ovf_v[k], cout_v[k], sum_v[k]}),
                        32'({1'b1, 1'b0, exp}));
        end
        in_valid_v[k]  = 1'b0;
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        checkOutput("back_to_idle", 32'({out_valid_v[k], in_ready_v[k], sum_v[k]}),
                    32'({1'b0, 1'b1, exp[15:0]}));
        out_ready_v[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
        end
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        rst_n = 1'b0;

        $display("[TB] reset check");
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_state",
                        32'({in_ready_v[k], out_valid_v[k], sum_v[k], cout_v[k], ovf_v[k]}),
                        32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", 32'({in_ready_v[0], out_valid_v[0]}), 32'b10);

        $display("[TB] directed operations, DIGIT=4");
        runOp(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        runOp(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        runOp(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        runOp(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        runOp(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        runOp(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);

        $display("[TB] backpressure with in_valid noise");
        runOp(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 10);
        runOp(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);

        $display("[TB] asynchronous reset in RUN");
        out_ready_v[0] = 1'b1;
        applyStimulus(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_reset",
                    32'({in_ready_v[0], out_valid_v[0], sum_v[0], cout_v[0], ovf_v[0]}),
                    32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_v[0] = 1'b0;
        @(negedge clk);
        runOp(0, 16'hABCD, 16'h1357, 1'b1, 1'b0, 0);

        $display("[TB] random sweep over DIGIT 4, 1, 16");
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 6; n++) begin
                runOp(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
